regfile_mp_scoreboard: RTL and testbench

//   Parametrised multi-port integer register file for the pipelined RISC-V core.

---
 rtl/regfile_mp_scoreboard.sv | 145 ++++++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard
//   Multi-port integer register file with a per-register busy scoreboard.
//   Reads are combinational, writes are synchronous, and write data can
//   optionally be forwarded to reads in the same cycle. Entry 0 reads as zero
//   and is never busy.
// Ports
//   clk, reset   rising-edge clock, async active-low reset
//   rd_addr      NRD*AW    read addresses, port p at [p*AW +: AW]
//   rd_data      NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//   rd_busy      NRD       addressed register has a pending producer
//   wr_en        NWR       write enable per write port
//   wr_addr      NWR*AW    write addresses
//   wr_data      NWR*XLEN  write data
//   busy_set     1         mark busy_addr pending (issue)
//   busy_addr    AW        register to mark pending
//   busy_cnt     AW+1      number of busy registers

// One read lane: array lookup, zero-register override and write forwarding.
module regfile_mp_scoreboard_rdport #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                rd_addr,
  input  logic [DEPTH-1:0][XLEN-1:0]   regs,
  input  logic [DEPTH-1:0]             busy,
  input  logic                         byp_ok,
  input  logic [NWR-1:0]               wr_en,
  input  logic [NWR-1:0][AW-1:0]       wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]     wr_data,
  output logic [XLEN-1:0]              rd_data,
  output logic                         rd_busy
);
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (rd_addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (BYPASS != 0 && byp_ok) begin
      // Ascending scan so the highest-index matching write port wins.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w] == rd_addr) begin
          rd_data = wr_data[w];
          rd_busy = 1'b0;
        end
      end
    end
  end
endmodule

module regfile_mp_scoreboard #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  output logic [AW:0]          busy_cnt
);
  if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_depth_chk
    $error("regfile_mp_scoreboard: DEPTH must be a power of 2 and >= 2");
  end
  if (NWR < 1 || NWR > 4) begin : g_nwr_chk
    $error("regfile_mp_scoreboard: NWR must be 1..4");
  end

  logic [NRD-1:0][AW-1:0]     rd_addr_a;
  logic [NRD-1:0][XLEN-1:0]   rd_data_a;
  logic [NWR-1:0][AW-1:0]     wr_addr_a;
  logic [NWR-1:0][XLEN-1:0]   wr_data_a;

  assign rd_addr_a = rd_addr;
  assign wr_addr_a = wr_addr;
  assign wr_data_a = wr_data;
  assign rd_data   = rd_data_a;

  logic [DEPTH-1:0][XLEN-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [AW:0]                busy_cnt_q, busy_cnt_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr_a[w] != '0) regs_d[wr_addr_a[w]] = wr_data_a[w];
    end
    // Writeback clears first; a same-cycle issue to that register re-marks it.
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_d[wr_addr_a[w]] = 1'b0;
    end
    if (busy_set && busy_addr != '0) busy_d[busy_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    // Count from the next-state bits so the count lands on the same edge.
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Forwarding is suppressed in reset so outputs reflect the cleared state.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_mp_scoreboard_rdport #(
      .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)
    ) u_rd (
      .rd_addr (rd_addr_a[p]),
      .regs    (regs_q),
      .busy    (busy_q),
      .byp_ok  (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr_a),
      .wr_data (wr_data_a),
      .rd_data (rd_data_a[p]),
      .rd_busy (rd_busy[p])
    );
  end
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
module tb_regfile_mp_scoreboard;
  logic        clk;
  logic        reset;

  // Main DUT: 2 read, 2 write ports, forwarding on.
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [5:0]  busy_cnt;

  // Second DUT: forwarding off.
  logic [4:0]  nb_rd_addr;
  logic [31:0] nb_rd_data;
  logic [0:0]  nb_rd_busy;
  logic [0:0]  nb_wr_en;
  logic [4:0]  nb_wr_addr;
  logic [31:0] nb_wr_data;
  logic        nb_busy_set;
  logic [4:0]  nb_busy_addr;
  logic [5:0]  nb_busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp_scoreboard #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_cnt(busy_cnt)
  );

  regfile_mp_scoreboard #(.XLEN(32), .DEPTH(32), .NRD(1), .NWR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(nb_rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data), .busy_set(nb_busy_set),
    .busy_addr(nb_busy_addr), .busy_cnt(nb_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        bs;
    logic [4:0]  ba;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_busy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [4:0] ra0, ra1, input logic [1:0] we,
                     input logic [4:0] wa0, wa1, input logic [31:0] wd0, wd1,
                     input logic bs, input logic [4:0] ba,
                     input logic [31:0] e_rd0, e_rd1, input logic [1:0] e_busy,
                     input logic [5:0] e_cnt);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa0 = wa0; v.wa1 = wa1;
    v.wd0 = wd0; v.wd1 = wd1; v.bs = bs; v.ba = ba;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; busy_set = 1'b0; busy_addr = '0;
    nb_rd_addr = '0; nb_wr_en = '0; nb_wr_addr = '0; nb_wr_data = '0;
    nb_busy_set = 1'b0; nb_busy_addr = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle();

    //       ra0 ra1 we     wa0 wa1 wd0           wd1      bs   ba    e_rd0         e_rd1         busy   cnt
    add(5'd5, 5'd7, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h0,        32'h0,        2'b00, 0);
    add(5'd5, 5'd0, 2'b01, 5, 0, 32'hDEADBEEF, 0,       1'b0, 0,  32'hDEADBEEF, 32'h0,        2'b00, 0);
    add(5'd5, 5'd0, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'hDEADBEEF, 32'h0,        2'b00, 0);
    add(5'd0, 5'd5, 2'b01, 0, 0, 32'h1234,     0,       1'b0, 0,  32'h0,        32'hDEADBEEF, 2'b00, 0);
    add(5'd0, 5'd5, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h0,        32'hDEADBEEF, 2'b00, 0);
    add(5'd5, 5'd7, 2'b01, 7, 0, 32'hA5A5A5A5, 0,       1'b0, 0,  32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 0);
    add(5'd3, 5'd3, 2'b11, 3, 3, 32'h1,        32'h2,   1'b0, 0,  32'h2,        32'h2,        2'b00, 0);
    add(5'd3, 5'd7, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h2,        32'hA5A5A5A5, 2'b00, 0);
    add(5'd9, 5'd9, 2'b00, 0, 0, 0,            0,       1'b1, 9,  32'h0,        32'h0,        2'b00, 0);
    add(5'd9, 5'd3, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h0,        32'h2,        2'b01, 1);
    add(5'd9, 5'd9, 2'b01, 9, 0, 32'h99,       0,       1'b1, 9,  32'h99,       32'h99,       2'b00, 1);
    add(5'd9, 5'd0, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h99,       32'h0,        2'b01, 1);
    add(5'd0, 5'd0, 2'b01, 9, 0, 32'h100,      0,       1'b0, 0,  32'h0,        32'h0,        2'b00, 1);
    add(5'd9, 5'd0, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h100,      32'h0,        2'b00, 0);
    add(5'd0, 5'd0, 2'b00, 0, 0, 0,            0,       1'b1, 0,  32'h0,        32'h0,        2'b00, 0);
    add(5'd0, 5'd0, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h0,        32'h0,        2'b00, 0);
    add(5'd6, 5'd0, 2'b11, 6, 0, 32'h66,       32'h77,  1'b0, 0,  32'h66,       32'h0,        2'b00, 0);
    add(5'd6, 5'd0, 2'b00, 0, 0, 0,            0,       1'b0, 0,  32'h66,       32'h0,        2'b00, 0);

    // Reset state.
    #3;
    check("reset_cnt", {26'd0, busy_cnt}, 32'd0);
    check("reset_rd0", rd_data[31:0], 32'd0);
    check("reset_busy", {30'd0, rd_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Forwarding disabled: old value and busy until the edge.
    @(negedge clk);
    nb_wr_en = 1'b1; nb_wr_addr = 5'd7; nb_wr_data = 32'h11111111;
    @(negedge clk);
    nb_wr_en = 1'b0; nb_busy_set = 1'b1; nb_busy_addr = 5'd7;
    @(negedge clk);
    nb_busy_set = 1'b0;
    nb_wr_en = 1'b1; nb_wr_addr = 5'd7; nb_wr_data = 32'hA5A5A5A5; nb_rd_addr = 5'd7;
    #1;
    check("nb_old_data", nb_rd_data, 32'h11111111);
    check("nb_old_busy", {31'd0, nb_rd_busy}, 32'd1);
    @(negedge clk);
    nb_wr_en = 1'b0;
    #1;
    check("nb_new_data", nb_rd_data, 32'hA5A5A5A5);
    check("nb_new_busy", {31'd0, nb_rd_busy}, 32'd0);
    check("nb_cnt", {26'd0, nb_busy_cnt}, 32'd0);

    // Vector table on the main DUT.
    foreach (vq[i]) begin
      @(negedge clk);
      rd_addr   = {vq[i].ra1, vq[i].ra0};
      wr_en     = vq[i].we;
      wr_addr   = {vq[i].wa1, vq[i].wa0};
      wr_data   = {vq[i].wd1, vq[i].wd0};
      busy_set  = vq[i].bs;
      busy_addr = vq[i].ba;
      #1;
      check($sformatf("v%0d_rd0", i), rd_data[31:0], vq[i].e_rd0);
      check($sformatf("v%0d_rd1", i), rd_data[63:32], vq[i].e_rd1);
      check($sformatf("v%0d_busy", i), {30'd0, rd_busy}, {30'd0, vq[i].e_busy});
      check($sformatf("v%0d_cnt", i), {26'd0, busy_cnt}, {26'd0, vq[i].e_cnt});
    end

    // Fill every register busy.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      idle();
      busy_set = 1'b1; busy_addr = a[4:0];
    end
    @(negedge clk);
    idle();
    rd_addr = {5'd31, 5'd1};
    #1;
    check("fill_cnt", {26'd0, busy_cnt}, 32'd31);
    check("fill_busy", {30'd0, rd_busy}, 32'd3);

    // Async reset while registers hold data.
    @(negedge clk);
    rd_addr = {5'd7, 5'd5};
    #1;
    check("pre_rst_rd0", rd_data[31:0], 32'hDEADBEEF);
    check("pre_rst_rd1", rd_data[63:32], 32'hA5A5A5A5);
    #1;
    reset = 1'b0;
    #1;
    check("async_rd0", rd_data[31:0], 32'd0);
    check("async_rd1", rd_data[63:32], 32'd0);
    check("async_busy", {30'd0, rd_busy}, 32'd0);
    check("async_cnt", {26'd0, busy_cnt}, 32'd0);

    // A write presented while reset is held is discarded.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h5555};
    busy_set = 1'b1; busy_addr = 5'd5;
    @(negedge clk);
    idle();
    reset = 1'b1;
    rd_addr = {5'd0, 5'd5};
    #1;
    check("rst_wr_discard", rd_data[31:0], 32'd0);
    check("rst_set_discard", {26'd0, busy_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
